mini_alu: RTL and testbench

MINI_ALU -- requirements
Module: mini_alu

---
 rtl/mini_alu.sv | 126 ++++++++++++
 tb/tb_mini_alu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mini_alu
//  Description : Single-cycle 8-bit-PC processor with a 256 x 28-bit
//                instruction ROM and a 16 x 16-bit register file. The
//                instruction at ROM[PC] is decoded and executed every cycle;
//                PC, registers and the LED register update on the rising edge.
//  Ports       : Clock  - rising-edge system clock
//                Reset  - asynchronous active-high reset
//                oLed   - registered 8-bit LED display value
//  Revision    : 1.0 - initial release
// ============================================================================
module mini_alu (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] oLed
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LED = 4'd1;
    localparam logic [3:0] OP_BLE = 4'd2;
    localparam logic [3:0] OP_STO = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    // Program image: counts R2 from 1 to 6 on the LEDs, then shows
    // (R2 * R3) and parks on a self-jump at address 10.
    function automatic logic [27:0] rom_lookup(input logic [7:0] addr);
        logic [27:0] word;
        case (addr)
            8'd1:    word = {OP_STO, 8'd1,  8'h00, 8'h01};
            8'd2:    word = {OP_STO, 8'd2,  8'h00, 8'h00};
            8'd3:    word = {OP_STO, 8'd3,  8'h00, 8'h05};
            8'd4:    word = {OP_ADD, 8'd2,  8'd2,  8'd1};
            8'd5:    word = {OP_LED, 8'd0,  8'd2,  8'd0};
            8'd6:    word = {OP_BLE, 8'd4,  8'd2,  8'd3};
            8'd7:    word = {OP_SUB, 8'd4,  8'd2,  8'd3};
            8'd8:    word = {OP_MUL, 8'd5,  8'd2,  8'd3};
            8'd9:    word = {OP_LED, 8'd0,  8'd5,  8'd0};
            8'd10:   word = {OP_JMP, 8'd10, 8'd0,  8'd0};
            default: word = {OP_NOP, 24'd0};
        endcase
        return word;
    endfunction

    logic [7:0]  pc_q, pc_d;
    logic [7:0]  led_q, led_d;
    logic [15:0] regs_q [16];

    logic [27:0] instr;
    logic [3:0]  opcode;
    logic [7:0]  dst_f, src1_f, src0_f;
    logic [15:0] rd1, rd0;
    logic [15:0] mul_lo;
    logic        wr_en;
    logic [15:0] wr_data;

    assign instr  = rom_lookup(pc_q);
    assign opcode = instr[27:24];
    assign dst_f  = instr[23:16];
    assign src1_f = instr[15:8];
    assign src0_f = instr[7:0];

    // Operands come from the pre-edge register contents, so an instruction
    // that reads and writes the same register sees the old value.
    assign rd1    = regs_q[src1_f[3:0]];
    assign rd0    = regs_q[src0_f[3:0]];
    // 16-bit context keeps only the low half of the product.
    assign mul_lo = rd1 * rd0;

    always_comb begin
        pc_d    = pc_q + 8'd1;      // natural wrap 255 -> 0
        led_d   = led_q;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        case (opcode)
            OP_LED: led_d = rd1[7:0];
            OP_BLE: begin
                if (rd1 <= rd0) begin
                    pc_d = dst_f;
                end
            end
            OP_STO: begin
                wr_en   = 1'b1;
                wr_data = {src1_f, src0_f};
            end
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = rd1 + rd0;
            end
            OP_JMP: pc_d = dst_f;
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = rd1 - rd0;
            end
            OP_MUL: begin
                wr_en   = 1'b1;
                wr_data = mul_lo;
            end
            default: ;              // NOP and unused opcodes 8..15
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q  <= 8'd0;
            led_q <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            pc_q  <= pc_d;
            led_q <= led_d;
            if (wr_en) begin
                regs_q[dst_f[3:0]] <= wr_data;
            end
        end
    end

    assign oLed = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mini_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mini_alu
//  Description : Self-checking bench for mini_alu. An instruction-level
//                model of the processor runs alongside the DUT; alternate
//                and random ROM images are applied by overriding the
//                fetched instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mini_alu;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] oLed;

    mini_alu dut (
        .Clock (Clock),
        .Reset (Reset),
        .oLed  (oLed)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    logic [27:0] prog [256];
    logic [27:0] forced_instr;

    // Instruction-level model state
    logic [7:0]  m_pc;
    logic [15:0] m_regs [16];
    logic [7:0]  m_led;

    int          cyc;
    logic [7:0]  prev_led;
    int          led_vals  [$];
    int          led_edges [$];

    task automatic model_reset();
        m_pc  = 8'd0;
        m_led = 8'h00;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    endtask

    task automatic model_step(input logic [27:0] ins);
        int a, b, npc;
        longint p;
        a   = int'(m_regs[ins[11:8]]);
        b   = int'(m_regs[ins[3:0]]);
        npc = (int'(m_pc) + 1) % 256;
        case (int'(ins[27:24]))
            1: m_led = 8'(a % 256);
            2: if (a <= b) npc = int'(ins[23:16]);
            3: m_regs[ins[19:16]] = 16'(int'(ins[15:8]) * 256 + int'(ins[7:0]));
            4: m_regs[ins[19:16]] = 16'((a + b) % 65536);
            5: npc = int'(ins[23:16]);
            6: m_regs[ins[19:16]] = 16'((a - b + 65536) % 65536);
            7: begin
                p = longint'(a) * longint'(b);
                m_regs[ins[19:16]] = 16'(p % 65536);
            end
            default: ;
        endcase
        m_pc = 8'(npc);
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) prog[i] = 28'd0;
        prog[1]  = {4'd3, 8'd1,  16'h0001};
        prog[2]  = {4'd3, 8'd2,  16'h0000};
        prog[3]  = {4'd3, 8'd3,  16'h0005};
        prog[4]  = {4'd4, 8'd2,  8'd2, 8'd1};
        prog[5]  = {4'd1, 8'd0,  8'd2, 8'd0};
        prog[6]  = {4'd2, 8'd4,  8'd2, 8'd3};
        prog[7]  = {4'd6, 8'd4,  8'd2, 8'd3};
        prog[8]  = {4'd7, 8'd5,  8'd2, 8'd3};
        prog[9]  = {4'd1, 8'd0,  8'd5, 8'd0};
        prog[10] = {4'd5, 8'd10, 8'd0, 8'd0};
    endtask

    // Hold reset briefly and release it on a falling edge.
    task automatic start_program();
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        model_reset();
        cyc      = 0;
        prev_led = 8'h00;
        led_vals.delete();
        led_edges.delete();
        Reset = 1'b0;
    endtask

    task automatic run_cycles(input int n, input bit use_force);
        int bad;
        for (int i = 0; i < n; i++) begin
            forced_instr = prog[m_pc];
            if (use_force) force dut.instr = forced_instr;
            model_step(forced_instr);
            @(negedge Clock);
            cyc++;
            checks++;
            if (dut.pc_q !== m_pc) begin
                errors++;
                $display("FAIL pc cycle %0d: got %0d expected %0d", cyc, dut.pc_q, m_pc);
            end
            checks++;
            if (oLed !== m_led) begin
                errors++;
                $display("FAIL oLed cycle %0d: got %02h expected %02h", cyc, oLed, m_led);
            end
            bad = -1;
            for (int j = 0; j < 16; j++)
                if (bad < 0 && dut.regs_q[j] !== m_regs[j]) bad = j;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL regs cycle %0d: R%0d got %04h expected %04h",
                         cyc, bad, dut.regs_q[bad], m_regs[bad]);
            end
            if (oLed !== prev_led) begin
                led_vals.push_back(int'(oLed));
                led_edges.push_back(cyc);
                prev_led = oLed;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++;
            if (oLed !== 8'h00) begin
                errors++;
                $display("FAIL reset_led: got %02h expected 00", oLed);
            end
            checks++;
            if (dut.pc_q !== 8'd0) begin
                errors++;
                $display("FAIL reset_pc: got %0d expected 0", dut.pc_q);
            end
        end
    endtask

    task automatic check_sequence(input string tag);
        int exp_v [7] = '{1, 2, 3, 4, 5, 6, 8'h1E};
        int exp_e [7] = '{6, 9, 12, 15, 18, 21, 25};
        checks++;
        if (led_vals.size() != 7) begin
            errors++;
            $display("FAIL %s_count: got %0d updates expected 7", tag, led_vals.size());
        end
        for (int i = 0; i < 7 && i < led_vals.size(); i++) begin
            checks++;
            if (led_vals[i] != exp_v[i] || led_edges[i] != exp_e[i]) begin
                errors++;
                $display("FAIL %s_update%0d: got %02h at edge %0d expected %02h at edge %0d",
                         tag, i, led_vals[i], led_edges[i], exp_v[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_default_program();
        load_default();
        start_program();
        run_cycles(30, 1'b0);
        check_sequence("seq");
        checks++;
        if (dut.regs_q[4] !== 16'h0001 || dut.regs_q[5] !== 16'h001E) begin
            errors++;
            $display("FAIL final_regs: got R4=%04h R5=%04h expected 0001 001E",
                     dut.regs_q[4], dut.regs_q[5]);
        end
    endtask

    task automatic test_loop_hold();
        run_cycles(20, 1'b0);
        checks++;
        if (dut.pc_q !== 8'd10 || oLed !== 8'h1E || led_vals.size() != 7) begin
            errors++;
            $display("FAIL hold: got pc=%0d led=%02h updates=%0d expected 10 1e 7",
                     dut.pc_q, oLed, led_vals.size());
        end
    endtask

    task automatic test_reset_mid_loop();
        int k = 0;
        load_default();
        start_program();
        while (oLed !== 8'h03 && k < 40) begin
            run_cycles(1, 1'b0);
            k++;
        end
        checks++;
        if (oLed !== 8'h03) begin
            errors++;
            $display("FAIL reach_led3: got %02h expected 03", oLed);
        end
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (oLed !== 8'h00 || dut.pc_q !== 8'd0 || dut.regs_q[2] !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got led=%02h pc=%0d R2=%04h expected 00 0 0000",
                     oLed, dut.pc_q, dut.regs_q[2]);
        end
        start_program();
        run_cycles(30, 1'b0);
        check_sequence("restart");
    endtask

    task automatic test_alt_rom();
        for (int i = 0; i < 256; i++) prog[i] = 28'd0;
        prog[0] = {4'd3, 8'd1, 16'hFFFF};
        prog[1] = {4'd3, 8'd2, 16'h0002};
        prog[2] = {4'd4, 8'd3, 8'd1, 8'd2};
        prog[3] = {4'd6, 8'd4, 8'd2, 8'd1};
        prog[4] = {4'd7, 8'd5, 8'd1, 8'd2};
        start_program();
        run_cycles(8, 1'b1);
        checks++;
        if (dut.regs_q[3] !== 16'h0001 || dut.regs_q[4] !== 16'h0003 ||
            dut.regs_q[5] !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_rules: got R3=%04h R4=%04h R5=%04h expected 0001 0003 fffe",
                     dut.regs_q[3], dut.regs_q[4], dut.regs_q[5]);
        end
    endtask

    task automatic test_random_programs();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin
                prog[i] = {4'($urandom_range(0, 9)), 4'd0, 4'($urandom_range(0, 15)),
                           8'($urandom), 8'($urandom)};
                if ($urandom_range(0, 3) == 0) prog[i][23:16] = 8'($urandom);
            end
            start_program();
            run_cycles(60, 1'b1);
        end
        release dut.instr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_program();
        test_loop_hold();
        test_reset_mid_loop();
        test_alt_rom();
        test_random_programs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
